ahb_lite_top: RTL and testbench
===============================

AHB_LITE_TOP -- requirements
Module: ahb_lite_top

Interface
REQ-001 Parameter/macro: `AHB_ADDR_WIDTH`, default 32, address bus width.
REQ-002 Parameter/macro: `AHB_DATA_WIDTH`, default 32, data bus width.
REQ-003 Parameter/macro: `CLK_FRE`, default 50, clock frequency in MHz.
REQ-004 Parameter/macro: `BAUD_RATE`, default 115200, UART bit rate; bit period BIT_CYC = CLK_FRE*1000000/BAUD_RATE clocks, integer-truncated.
REQ-005 Port: clk, input, 1, single system clock; all logic is rising-edge.
REQ-006 Port: rstn, input, 1, reset; asynchronous, active-low.
REQ-007 Port: haddr_i, input, AHB_ADDR_WIDTH, master address.
REQ-008 Port: hwrite_i, input, 1, 1 = write, 0 = read; valid with haddr_ctrl_i.
REQ-009 Port: haddr_ctrl_i, input, 1, address-phase valid strobe.
REQ-010 Port: hwdata_i, input, AHB_DATA_WIDTH, write data, valid the cycle after the address phase.
REQ-011 Port: hbusreq_i, input, 1, bus request from the single master.
REQ-012 Port: rx_pin, input, 1, UART receive line; idle high.
REQ-013 Port: tx_pin, output, 1, UART transmit line; idle high.

Function
REQ-014 Arbiter: internal hgrant is hbusreq_i registered by one clock; it deasserts the edge after hbusreq_i falls.
REQ-015 Address phase is accepted on a rising edge where hgrant=1 and haddr_ctrl_i=1; haddr, hwrite and the slave select are latched on that edge.
REQ-016 Address phase with hgrant=0 is ignored.
REQ-017 Decode on haddr[31:30]:
  - 2'b11: RAM.
  - 2'b01: control register CTRL.
  - 2'b00: UART.
  - 2'b10: reserved; writes are dropped and reads return 0.
REQ-018 Data phase is the cycle after address acceptance.
  - Write: hwdata_i is sampled on the data-phase closing edge and the target is updated on that edge.
  - No wait states; hready is internally always 1.
REQ-019 Read: internal signal hrdata carries the selected slave's data during the data phase; it is 0 outside a read data phase.
REQ-020 RAM: 256 x 32, word index = haddr[7:0], no byte lanes; read returns the stored word; contents are not reset (undefined until written).
REQ-021 CTRL: 32-bit read/write register.
  - Bit0 = TX_EN.
  - Bit1 = RX_EN (meaningful only with UART_RX_EN).
  - Other bits are storage only.
  - Read returns the full register.
REQ-022 UART write with TX_EN=1 and the transmitter idle: sends one frame on tx_pin.
  - Frame: start bit (0), the 32 data bits LSB first, stop bit (1).
  - Every bit lasts BIT_CYC clocks, so 34 bit periods in total.
  - The first bit starts the cycle after the data phase.
REQ-023 A UART write while TX_EN=0 or while transmitting is dropped silently; an in-progress frame always completes even if TX_EN is cleared mid-frame.
REQ-024 A UART read returns RXDATA (see Configuration).
REQ-025 A new address phase may be accepted during the data phase of the previous transfer (pipelined).
  - Back-to-back write-then-read to the same RAM word returns the new data.

Reset
REQ-026 On rstn low:
  - hgrant=0 and CTRL=0.
  - Address/data-phase state cleared; hrdata=0.
  - UART FSMs idle; tx_pin=1; RXDATA=0.
REQ-027 Reset asserted mid-frame aborts the frame with tx_pin returning to 1 immediately; RAM contents are preserved.

Configuration
REQ-028 Macro UART_RX_EN defined:
  - Receiver samples rx_pin when CTRL.RX_EN=1.
  - Frame format is the same as REQ-022: start bit detected on a falling edge, sampled mid-bit.
  - The 32-bit word is stored in RXDATA at the stop bit.
  - A bad stop bit discards the word.
REQ-029 Macro UART_RX_EN undefined: no receiver logic; rx_pin is ignored and UART reads return 0.

Structure
REQ-030 Shared package ahb_lite_pkg holds:
  - Slave-select encodings.
  - The RAM depth/index width constants.
  - The 34-bit UART frame length.
  - The CTRL bit positions.
REQ-031 The width, clock and baud macros come from const_defines.v.
REQ-032 Sub-module ahb_uart contains the TX (and optional RX) bit-timing FSMs: IDLE, START, DATA (32 bits), STOP.

Verification
REQ-033 Write 0x12345678 to 0xDDFFCCDD and 0x87654321 to 0xDDFFCCDF, then read both -> hrdata 0x12345678 then 0x87654321.
REQ-034 Write CTRL (0x5DFFCCDD) = 0x1234567F, then read it -> hrdata 0x1234567F.
REQ-035 With TX_EN=1, write UART (0x1DFFCCDD) = 0xEECCA1A1 -> tx_pin shows 0, 32 bits of 0xEECCA1A1 LSB first, then 1, each bit BIT_CYC clocks; tx_pin then idle at 1.
REQ-036 Write CTRL = 0x12345670, then write UART -> tx_pin stays 1.
REQ-037 Address phase with hbusreq_i low -> no RAM/CTRL change; rstn pulse mid-TX -> tx_pin=1 and CTRL=0.
REQ-038 With UART_RX_EN and RX_EN=1, drive a 34-bit frame carrying 0xA5A5_0F0F on rx_pin, then read UART -> hrdata 0xA5A50F0F.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: slave-select codes, RAM sizing, UART frame length and CTRL bit positions.
// Also supplies the const_defines defaults for AHB_ADDR_WIDTH, AHB_DATA_WIDTH, CLK_FRE, BAUD_RATE.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif
`ifndef CLK_FRE
`define CLK_FRE 50
`endif
`ifndef BAUD_RATE
`define BAUD_RATE 115200
`endif

package ahb_lite_pkg;
    typedef enum logic [1:0] {
        SEL_UART = 2'b00,
        SEL_CTRL = 2'b01,
        SEL_RSVD = 2'b10,
        SEL_RAM  = 2'b11
    } sel_e;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_e;

    localparam int RAM_DEPTH  = 256;
    localparam int RAM_IW     = 8;
    localparam int FRAME_BITS = 34;
    localparam int CTRL_TX_EN = 0;
    localparam int CTRL_RX_EN = 1;
endpackage

// File: rtl/ahb_lite_uart.sv
// ahb_uart: start/data/stop bit-timing FSMs; transmitter always present,
// receiver only when UART_RX_EN is defined (otherwise RXDATA reads as 0).
module ahb_uart
    import ahb_lite_pkg::*;
#(
    parameter int DW      = 32,
    parameter int BIT_CYC = 434
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          tx_en,
    input  logic          rx_en,
    input  logic          tx_req,
    input  logic [DW-1:0] tx_data,
    input  logic          rx_pin,
    output logic          tx_pin,
    output logic [DW-1:0] rxdata
);
    localparam int CW = $clog2(BIT_CYC + 1);
    localparam int IW = $clog2(DW);

    uart_st_e      tx_st, tx_nx;
    logic [CW-1:0] tx_cyc;
    logic [IW-1:0] tx_idx;
    logic [DW-1:0] tx_sh;
    logic          tx_tick;

    assign tx_tick = tx_cyc == CW'(BIT_CYC - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tx_st <= ST_IDLE;
        else       tx_st <= tx_nx;
    end

    always_comb begin
        tx_nx = tx_st;
        case (tx_st)
            ST_IDLE:  tx_nx = tx_req && tx_en ? ST_START : ST_IDLE;
            ST_START: tx_nx = tx_tick ? ST_DATA : ST_START;
            ST_DATA:  tx_nx = tx_tick && tx_idx == IW'(DW - 1) ? ST_STOP : ST_DATA;
            ST_STOP:  tx_nx = tx_tick ? ST_IDLE : ST_STOP;
            default:  tx_nx = ST_IDLE;
        endcase
        tx_pin = tx_st == ST_START ? 1'b0 : tx_st == ST_DATA ? tx_sh[0] : 1'b1;
    end

    // The shifter tracks the write bus while idle so the launching word is captured on the start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_cyc <= '0;
            tx_idx <= '0;
            tx_sh  <= '0;
        end else begin
            tx_cyc <= tx_st == ST_IDLE || tx_tick ? '0 : tx_cyc + 1'b1;
            tx_idx <= tx_st != ST_DATA ? '0 : tx_idx + IW'(tx_tick);
            tx_sh  <= tx_st == ST_IDLE ? tx_data : tx_st == ST_DATA && tx_tick ? tx_sh >> 1 : tx_sh;
        end
    end

`ifdef UART_RX_EN
    uart_st_e      rx_st, rx_nx;
    logic [CW-1:0] rx_cyc;
    logic [IW-1:0] rx_idx;
    logic [DW-1:0] rx_sh;
    logic [1:0]    rx_sync;
    logic          rx_prev, rx_bit, rx_tick;

    assign rx_bit  = rx_sync[1];
    assign rx_tick = rx_cyc == CW'(rx_st == ST_START ? BIT_CYC / 2 - 1 : BIT_CYC - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rx_st <= ST_IDLE;
        else       rx_st <= rx_nx;
    end

    // Start waits half a bit so every later tick lands mid-bit.
    always_comb begin
        rx_nx = rx_st;
        case (rx_st)
            ST_IDLE:  rx_nx = rx_en && rx_prev && !rx_bit ? ST_START : ST_IDLE;
            ST_START: rx_nx = !rx_tick ? ST_START : rx_bit ? ST_IDLE : ST_DATA;
            ST_DATA:  rx_nx = rx_tick && rx_idx == IW'(DW - 1) ? ST_STOP : ST_DATA;
            ST_STOP:  rx_nx = rx_tick ? ST_IDLE : ST_STOP;
            default:  rx_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
            rx_cyc  <= '0;
            rx_idx  <= '0;
            rx_sh   <= '0;
            rxdata  <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rx_pin};
            rx_prev <= rx_bit;
            rx_cyc  <= rx_st == ST_IDLE || rx_tick ? '0 : rx_cyc + 1'b1;
            rx_idx  <= rx_st != ST_DATA ? '0 : rx_idx + IW'(rx_tick);
            rx_sh   <= rx_st == ST_DATA && rx_tick ? {rx_bit, rx_sh[DW-1:1]} : rx_sh;
            rxdata  <= rx_st == ST_STOP && rx_tick && rx_bit ? rx_sh : rxdata;
        end
    end
`else
    logic unused_rx;
    assign unused_rx = ^{rx_pin, rx_en};
    assign rxdata    = '0;
`endif
endmodule

// File: rtl/ahb_lite_top.sv
// ahb_lite_top: single-master AHB-Lite slave slice with RAM, CTRL register and UART.
// Define UART_RX_EN to build the UART receiver.
module ahb_lite_top
    import ahb_lite_pkg::*;
#(
    parameter int AW       = `AHB_ADDR_WIDTH,
    parameter int DW       = `AHB_DATA_WIDTH,
    parameter int CLK_FRE  = `CLK_FRE,
    parameter int BAUD     = `BAUD_RATE,
    parameter int BIT_CYC  = CLK_FRE * 1000000 / BAUD
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] haddr_i,
    input  logic          hwrite_i,
    input  logic          haddr_ctrl_i,
    input  logic [DW-1:0] hwdata_i,
    input  logic          hbusreq_i,
    input  logic          rx_pin,
    output logic          tx_pin
);
    logic              hgrant, dp_valid, dp_write, wr, rd;
    sel_e              dp_sel;
    logic [RAM_IW-1:0] dp_idx;
    logic [DW-1:0]     ctrl, rxdata, hrdata;
    logic [DW-1:0]     ram [RAM_DEPTH];

    assign wr = dp_valid && dp_write;
    assign rd = dp_valid && !dp_write;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hgrant   <= 1'b0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_sel   <= SEL_UART;
            dp_idx   <= '0;
            ctrl     <= '0;
        end else begin
            hgrant   <= hbusreq_i;
            dp_valid <= hgrant && haddr_ctrl_i;
            if (hgrant && haddr_ctrl_i) begin
                dp_write <= hwrite_i;
                dp_sel   <= sel_e'(haddr_i[AW-1:AW-2]);
                dp_idx   <= haddr_i[RAM_IW-1:0];
            end
            if (wr && dp_sel == SEL_CTRL) ctrl <= hwdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && dp_sel == SEL_RAM) ram[dp_idx] <= hwdata_i;
    end

    always_comb begin
        hrdata = !rd ? '0 : dp_sel == SEL_RAM ? ram[dp_idx] : dp_sel == SEL_CTRL ? ctrl :
                 dp_sel == SEL_UART ? rxdata : '0;
    end

    // The read bus has no port in this slice; fold it and the undecoded address bits into a sink.
    logic unused_top;
    assign unused_top = ^{haddr_i[AW-3:RAM_IW], hrdata};

    ahb_uart #(.DW(DW), .BIT_CYC(BIT_CYC)) u_uart (
        .clk     (clk),
        .rstn    (rstn),
        .tx_en   (ctrl[CTRL_TX_EN]),
        .rx_en   (ctrl[CTRL_RX_EN]),
        .tx_req  (wr && dp_sel == SEL_UART),
        .tx_data (hwdata_i),
        .rx_pin  (rx_pin),
        .tx_pin  (tx_pin),
        .rxdata  (rxdata)
    );
endmodule

// File: tb/tb_ahb_lite_top.sv
// tb_ahb_lite_top: directed plus randomized bus traffic against a behavioural
// memory/register/UART-frame model; peeks the internal hgrant, ctrl and hrdata.
module tb_ahb_lite_top;
    localparam int B = 50 * 1000000 / 115200;

    logic        clk = 0, rstn = 0;
    logic [31:0] haddr_i = 0, hwdata_i = 0;
    logic        hwrite_i = 0, haddr_ctrl_i = 0, hbusreq_i = 0, rx_pin = 1;
    logic        tx_pin;

    int          vecs = 0, errs = 0;
    logic [31:0] m_ram [256];
    bit          m_val [256];
    logic [31:0] m_ctrl = 0, m_rx = 0;

    always #10 clk = ~clk;

    ahb_lite_top dut (
        .clk(clk), .rstn(rstn), .haddr_i(haddr_i), .hwrite_i(hwrite_i),
        .haddr_ctrl_i(haddr_ctrl_i), .hwdata_i(hwdata_i), .hbusreq_i(hbusreq_i),
        .rx_pin(rx_pin), .tx_pin(tx_pin)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_write(input logic [31:0] a, input logic [31:0] d);
        case (a[31:30])
            2'b11: begin m_ram[a[7:0]] = d; m_val[a[7:0]] = 1; end
            2'b01: m_ctrl = d;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[31:30])
            2'b11:   return m_ram[a[7:0]];
            2'b01:   return m_ctrl;
            2'b00:   return m_rx;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] rand_addr(input logic [1:0] region, input logic [7:0] idx);
        logic [21:0] mid;
        mid = 22'($urandom);
        return {region, mid, idx};
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input bit upd = 1);
        @(posedge clk) #1;
        haddr_i = a; hwrite_i = 1; haddr_ctrl_i = 1;
        @(posedge clk) #1;
        haddr_ctrl_i = 0; hwdata_i = d;
        @(posedge clk) #1;
        if (upd) m_write(a, d);
    endtask

    task automatic bus_read(input logic [31:0] a, input string tag);
        @(posedge clk) #1;
        haddr_i = a; hwrite_i = 0; haddr_ctrl_i = 1;
        @(posedge clk) #1;
        haddr_ctrl_i = 0;
        @(negedge clk);
        check(tag, dut.hrdata, m_read(a));
        @(posedge clk);
        @(negedge clk);
        check("hrdata_idle", dut.hrdata, 0);
    endtask

    task automatic wr_rd(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk) #1;
        haddr_i = a; hwrite_i = 1; haddr_ctrl_i = 1;
        @(posedge clk) #1;
        hwdata_i = d; hwrite_i = 0;
        @(posedge clk) #1;
        haddr_ctrl_i = 0;
        m_write(a, d);
        @(negedge clk);
        check("pipe_wr_rd", dut.hrdata, m_read(a));
    endtask

    task automatic tx_frame_check(input logic [31:0] d);
        logic [33:0] f;
        f = {1'b1, d, 1'b0};
        for (int i = 0; i < 34 * B; i++) begin
            @(negedge clk);
            check($sformatf("tx_bit%0d", i / B), tx_pin, f[i / B]);
        end
        for (int i = 0; i < B; i++) begin
            @(negedge clk);
            check("tx_after_frame", tx_pin, 1);
        end
    endtask

    task automatic rx_send(input logic [31:0] d, input logic stop);
        logic [33:0] f;
        f = {stop, d, 1'b0};
        for (int k = 0; k < 34; k++) begin
            rx_pin = f[k];
            repeat (B) @(posedge clk);
        end
        rx_pin = 1;
        repeat (B) @(posedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  idx;
        #5;
        check("rst_tx_pin", tx_pin, 1);
        check("rst_hgrant", dut.hgrant, 0);
        check("rst_hrdata", dut.hrdata, 0);
        check("rst_ctrl", dut.ctrl, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1; hbusreq_i = 1;
        @(posedge clk) #1;
        check("grant_up", dut.hgrant, 1);

        bus_write(32'hDDFFCCDD, 32'h12345678);
        bus_write(32'hDDFFCCDF, 32'h87654321);
        bus_read(32'hDDFFCCDD, "ram_rd_dd");
        bus_read(32'hDDFFCCDF, "ram_rd_df");
        bus_write(32'h5DFFCCDD, 32'h1234567F);
        bus_read(32'h5DFFCCDD, "ctrl_rd");

        for (int n = 0; n < 40; n++) begin
            idx = 8'($urandom_range(0, 15));
            d   = $urandom;
            case ($urandom_range(0, 5))
                0: bus_write(rand_addr(2'b11, idx), d);
                1: if (m_val[idx]) bus_read(rand_addr(2'b11, idx), "rand_ram_rd");
                2: bus_write(rand_addr(2'b01, idx), d & 32'hFFFF_FFFE);
                3: bus_read(rand_addr(2'b01, idx), "rand_ctrl_rd");
                4: begin
                    bus_write(rand_addr(2'b10, idx), d);
                    bus_read(rand_addr(2'b10, idx), "rsvd_rd");
                end
                default: wr_rd(rand_addr(2'b11, idx), d);
            endcase
        end

        @(posedge clk) #1 hbusreq_i = 0;
        @(negedge clk);
        check("grant_hold", dut.hgrant, 1);
        @(posedge clk) #1;
        check("grant_drop", dut.hgrant, 0);
        bus_write(32'hDDFFCCDD, 32'hDEADBEEF, 0);
        bus_write(32'h5DFFCCDD, 32'hCAFEF00D, 0);
        hbusreq_i = 1;
        @(posedge clk);
        bus_read(32'hDDFFCCDD, "nogrant_ram");
        bus_read(32'h5DFFCCDD, "nogrant_ctrl");

        bus_write(32'h5DFFCCDD, 32'h0000_0001);
        bus_write(32'h1DFFCCDD, 32'hEECCA1A1);
        fork
            tx_frame_check(32'hEECCA1A1);
            begin
                repeat (200) @(posedge clk);
                bus_write(32'h1DFFCCDD, 32'h5555AAAA);
                bus_write(32'h5DFFCCDD, 32'h0000_0000);
            end
        join
        bus_read(32'h5DFFCCDD, "ctrl_cleared");

        bus_write(32'h5DFFCCDD, 32'h12345670);
        bus_write(32'h1DFFCCDD, 32'hEECCA1A1);
        for (int i = 0; i < 2 * B; i++) begin
            @(negedge clk);
            check("tx_disabled", tx_pin, 1);
        end

        bus_write(32'h5DFFCCDD, 32'h0000_0001);
        bus_write(32'h1DFFCCDD, $urandom);
        repeat (100) @(negedge clk);
        check("tx_started", tx_pin, 0);
        #2 rstn = 0;
        #1;
        m_ctrl = 0;
        check("midtx_rst_tx_pin", tx_pin, 1);
        check("midtx_rst_ctrl", dut.ctrl, 0);
        check("midtx_rst_hgrant", dut.hgrant, 0);
        check("midtx_rst_hrdata", dut.hrdata, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        for (int i = 0; i < B; i++) begin
            @(negedge clk);
            check("tx_after_rst", tx_pin, 1);
        end
        bus_read(32'hDDFFCCDD, "ram_kept_dd");
        bus_read(32'hDDFFCCDF, "ram_kept_df");
        bus_read(32'h5DFFCCDD, "ctrl_after_rst");

        bus_write(32'h5DFFCCDD, 32'h0000_0003);
`ifdef UART_RX_EN
        rx_send(32'hA5A50F0F, 1);
        m_rx = 32'hA5A50F0F;
        bus_read(32'h1DFFCCDD, "rx_word");
        rx_send($urandom, 0);
        bus_read(32'h1DFFCCDD, "rx_bad_stop");
        d = $urandom;
        rx_send(d, 1);
        m_rx = d;
        bus_read(32'h1DFFCCDD, "rx_rand_word");
`else
        rx_send(32'hA5A50F0F, 1);
        bus_read(32'h1DFFCCDD, "rx_absent");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
